// File: rtl/rf_writeback_queue.sv
// In-order writeback queue merging load and ALU requests onto one register-file write port.
// Head drives rf_* one cycle after acceptance; readies drop conservatively as the queue fills.
module rf_writeback_queue #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int DROP_R0 = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    mem_valid_i,
  output logic                    mem_ready_o,
  input  logic [ADDR_W-1:0]       mem_addr_i,
  input  logic [DATA_W-1:0]       mem_data_i,
  input  logic                    alu_valid_i,
  output logic                    alu_ready_o,
  input  logic [ADDR_W-1:0]       alu_addr_i,
  input  logic [DATA_W-1:0]       alu_data_i,
  output logic                    rf_we_o,
  output logic [ADDR_W-1:0]       rf_addr_o,
  output logic [DATA_W-1:0]       rf_data_o,
  input  logic [ADDR_W-1:0]       pend_addr_i,
  output logic                    pend_hit_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] ALMOST = CW'(DEPTH - 1);

  logic [ADDR_W-1:0] addrQ [DEPTH];
  logic [DATA_W-1:0] dataQ [DEPTH];
  logic [DEPTH-1:0]  vldQ, vldNext;
  logic [PW-1:0]     wrPtr, rdPtr, aluPtr;
  logic [CW-1:0]     count;
  logic              memRdy, aluRdy, memDrop, aluDrop, memEnq, aluEnq, pop, pendHit;

  // Readies are gated by reset so both sources see "not ready" while it is held.
  assign memRdy  = rst_ni && (count < FULL);
  assign aluRdy  = rst_ni && ((count < ALMOST) || ((count < FULL) && !mem_valid_i));
  assign memDrop = (DROP_R0 != 0) && (mem_addr_i == '0);
  assign aluDrop = (DROP_R0 != 0) && (alu_addr_i == '0);
  assign memEnq  = mem_valid_i && memRdy && !memDrop;
  assign aluEnq  = alu_valid_i && aluRdy && !aluDrop;
  assign pop     = (count != '0);
  // The load entry is older, so it takes the first free slot and the ALU entry the next.
  assign aluPtr  = wrPtr + PW'(memEnq);

  always_comb begin
    vldNext = vldQ;
    if (pop)    vldNext[rdPtr]  = 1'b0;
    if (memEnq) vldNext[wrPtr]  = 1'b1;
    if (aluEnq) vldNext[aluPtr] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      vldQ  <= '0;
    end else begin
      wrPtr <= aluPtr + PW'(aluEnq);
      if (pop) rdPtr <= rdPtr + PW'(1);
      count <= count + CW'(memEnq) + CW'(aluEnq) - CW'(pop);
      vldQ  <= vldNext;
    end
  end

  always_ff @(posedge clk_i) begin
    if (memEnq) begin
      addrQ[wrPtr] <= mem_addr_i;
      dataQ[wrPtr] <= mem_data_i;
    end
    if (aluEnq) begin
      addrQ[aluPtr] <= alu_addr_i;
      dataQ[aluPtr] <= alu_data_i;
    end
  end

  always_comb begin
    pendHit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vldQ[i] && (addrQ[i] == pend_addr_i)) pendHit = 1'b1;
    end
    if ((DROP_R0 != 0) && (pend_addr_i == '0)) pendHit = 1'b0;
  end

  assign mem_ready_o = memRdy;
  assign alu_ready_o = aluRdy;
  assign rf_we_o     = pop;
  assign rf_addr_o   = addrQ[rdPtr];
  assign rf_data_o   = dataQ[rdPtr];
  assign pend_hit_o  = pendHit;
  assign count_o     = count;

endmodule
